// File: rtl/jt9346_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : jt9346_ctrl
// Brief    : Serial initiator for 93C46/93C06-compatible EEPROMs. Takes one
//            parallel command, drives scs/sclk/sdi, captures sdo read data
//            and polls ready/busy after programming commands.
// Revision : 1.0 - initial release
// ============================================================================
module jt9346_ctrl #(
  parameter int AW     = 6,
  parameter int DW     = 16,
  parameter int CLKDIV = 4,
  parameter int TOUT   = 65535
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_data,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          done,
  output logic          err,
  output logic          sclk,
  output logic          sdi,
  output logic          scs,
  input  logic          sdo
);

  // Frame geometry: start bit + 2 opcode bits + address, optionally DW data bits
  localparam int c_HDR  = 3 + AW;
  localparam int c_FW   = c_HDR + DW;
  localparam int c_CMAX = (TOUT > 2*CLKDIV) ? TOUT : 2*CLKDIV;
  localparam int c_CW   = $clog2(c_CMAX + 1);
  localparam int c_BW   = $clog2(c_FW + 1);

  localparam logic [c_CW-1:0] c_HALF_LAST  = c_CW'(CLKDIV - 1);
  localparam logic [c_CW-1:0] c_DESEL_LAST = c_CW'(2*CLKDIV - 1);
  localparam logic [c_CW-1:0] c_POLL_WAIT  = c_CW'(CLKDIV);
  localparam logic [c_CW-1:0] c_TOUT_LAST  = c_CW'(TOUT - 1);
  localparam logic [c_BW-1:0] c_HDR_LAST   = c_BW'(c_HDR - 1);
  localparam logic [c_BW-1:0] c_FULL_LAST  = c_BW'(c_FW - 1);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_SETUP  = 3'd1;
  localparam logic [2:0] c_SHIFT  = 3'd2;
  localparam logic [2:0] c_READ   = 3'd3;
  localparam logic [2:0] c_DESEL  = 3'd4;
  localparam logic [2:0] c_POLL   = 3'd5;
  localparam logic [2:0] c_DESEL2 = 3'd6;
  localparam logic [2:0] c_DONE   = 3'd7;

  logic [2:0]      r_state;
  logic [c_CW-1:0] r_cnt;
  logic [c_BW-1:0] r_bit;
  logic [c_BW-1:0] r_last;
  logic [c_FW-1:0] r_sreg;
  logic [DW-2:0]   r_shift;
  logic            r_read;
  logic            r_poll;
  logic            r_fail;
  logic [DW-1:0]   r_rd_data;
  logic            r_rd_valid;
  logic            r_done;
  logic            r_err;
  logic            r_sclk;
  logic            r_sdi;
  logic            r_scs;
  logic            r_ready;

  logic [1:0]      w_opbits;
  logic [AW-1:0]   w_afield;
  logic            w_wdata;
  logic            w_read;
  logic            w_poll;
  logic [c_FW-1:0] w_frame;
  logic [c_BW-1:0] w_last;
  logic [DW-1:0]   w_shift_nxt;

  // Decode the requested command into opcode bits, address field and flags
  always_comb begin
    w_opbits = 2'b00;
    w_afield = '0;
    w_wdata  = 1'b0;
    w_read   = 1'b0;
    w_poll   = 1'b0;
    case (cmd_op)
      3'd0: begin w_opbits = 2'b10; w_afield = cmd_addr; w_read = 1'b1; end
      3'd1: begin w_opbits = 2'b01; w_afield = cmd_addr; w_wdata = 1'b1; w_poll = 1'b1; end
      3'd2: begin w_opbits = 2'b11; w_afield = cmd_addr; w_poll = 1'b1; end
      3'd3: w_afield[AW-1:AW-2] = 2'b11;
      3'd4: w_afield[AW-1:AW-2] = 2'b00;
      3'd5: begin w_afield[AW-1:AW-2] = 2'b10; w_poll = 1'b1; end
      3'd6: begin w_afield[AW-1:AW-2] = 2'b01; w_wdata = 1'b1; w_poll = 1'b1; end
      default: w_opbits = 2'b00;
    endcase
  end

  // READ clocks the DW data bits too, so it shares the long frame length
  assign w_frame     = {1'b1, w_opbits, w_afield, (w_wdata ? cmd_data : {DW{1'b0}})};
  assign w_last      = (w_wdata || w_read) ? c_FULL_LAST : c_HDR_LAST;
  assign w_shift_nxt = {r_shift, sdo};

  // Command sequencer: frame shifting, read capture, ready polling, completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_IDLE;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_last     <= '0;
      r_sreg     <= '0;
      r_shift    <= '0;
      r_read     <= 1'b0;
      r_poll     <= 1'b0;
      r_fail     <= 1'b0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_sclk     <= 1'b0;
      r_sdi      <= 1'b0;
      r_scs      <= 1'b0;
      r_ready    <= 1'b1;
    end else begin
      r_rd_valid <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      case (r_state)
        c_IDLE: begin
          r_ready <= 1'b1;
          if (cmd_valid && r_ready) begin
            r_ready <= 1'b0;
            if (cmd_op == 3'd7) begin
              // Reserved op: no pin activity, immediate error completion
              r_done <= 1'b1;
              r_err  <= 1'b1;
            end else begin
              r_state <= c_SETUP;
              r_scs   <= 1'b1;
              r_sdi   <= 1'b1;
              r_cnt   <= '0;
              r_bit   <= '0;
              r_sreg  <= w_frame << 1;
              r_last  <= w_last;
              r_read  <= w_read;
              r_poll  <= w_poll;
              r_fail  <= 1'b0;
            end
          end
        end
        c_SETUP: begin
          if (r_cnt == c_HALF_LAST) begin
            r_cnt   <= '0;
            r_sclk  <= 1'b1;
            r_state <= c_SHIFT;
          end else begin
            r_cnt <= r_cnt + c_CW'(1);
          end
        end
        c_SHIFT, c_READ: begin
          if (r_cnt != c_HALF_LAST) begin
            r_cnt <= r_cnt + c_CW'(1);
          end else begin
            r_cnt <= '0;
            if (!r_sclk) begin
              r_sclk <= 1'b1;
            end else begin
              // Last high cycle: sample sdo, drop sclk, present next bit
              r_sclk <= 1'b0;
              r_sdi  <= r_sreg[c_FW-1];
              r_sreg <= {r_sreg[c_FW-2:0], 1'b0};
              if (r_read && (r_bit == c_HDR_LAST) && sdo)
                r_fail <= 1'b1;
              if (r_read && (r_bit > c_HDR_LAST))
                r_shift <= w_shift_nxt[DW-2:0];
              if (r_bit == r_last) begin
                r_scs   <= 1'b0;
                r_state <= c_DESEL;
                if (r_read) begin
                  r_rd_data  <= w_shift_nxt;
                  r_rd_valid <= 1'b1;
                end
              end else begin
                r_bit <= r_bit + c_BW'(1);
                if (r_read && (r_bit == c_HDR_LAST))
                  r_state <= c_READ;
              end
            end
          end
        end
        c_DESEL: begin
          if (r_cnt == c_DESEL_LAST) begin
            r_cnt <= '0;
            if (r_poll) begin
              r_state <= c_POLL;
              r_scs   <= 1'b1;
            end else begin
              r_state <= c_DONE;
            end
          end else begin
            r_cnt <= r_cnt + c_CW'(1);
          end
        end
        c_POLL: begin
          // Timeout budget covers the whole POLL residency including the settle wait
          if ((r_cnt >= c_POLL_WAIT) && sdo) begin
            r_scs   <= 1'b0;
            r_cnt   <= '0;
            r_state <= c_DESEL2;
          end else if (r_cnt == c_TOUT_LAST) begin
            r_fail  <= 1'b1;
            r_scs   <= 1'b0;
            r_cnt   <= '0;
            r_state <= c_DESEL2;
          end else begin
            r_cnt <= r_cnt + c_CW'(1);
          end
        end
        c_DESEL2: begin
          if (r_cnt == c_DESEL_LAST) begin
            r_cnt   <= '0;
            r_state <= c_DONE;
          end else begin
            r_cnt <= r_cnt + c_CW'(1);
          end
        end
        c_DONE: begin
          r_done  <= 1'b1;
          r_err   <= r_fail;
          r_state <= c_IDLE;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign cmd_ready = r_ready;
  assign rd_data   = r_rd_data;
  assign rd_valid  = r_rd_valid;
  assign done      = r_done;
  assign err       = r_err;
  assign sclk      = r_sclk;
  assign sdi       = r_sdi;
  assign scs       = r_scs;

endmodule
`default_nettype wire

// File: tb/tb_jt9346_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_jt9346_ctrl
// Brief    : Directed bench for jt9346_ctrl with a small 93C46 memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jt9346_ctrl;
  localparam int AW = 6, DW = 16, CLKDIV = 4, TOUT = 200, BUSY = 30;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [2:0] cmd_op = 3'd0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_data = '0;
  logic [DW-1:0] rd_data;
  logic rd_valid, done, err, sclk, sdi, scs, sdo;

  always #5 clk = ~clk;

  jt9346_ctrl #(.AW(AW), .DW(DW), .CLKDIV(CLKDIV), .TOUT(TOUT)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err),
    .sclk(sclk), .sdi(sdi), .scs(scs), .sdo(sdo)
  );

  // ---------------- EEPROM model ----------------
  logic [15:0] mem [0:63] = '{default: 16'h0000};
  logic        m_ewen = 1'b0, m_rd_mode = 1'b0, m_rd_bit = 1'b0;
  logic        m_psclk = 1'b0, m_pscs = 1'b0;
  logic [31:0] m_rx = '0;
  logic [15:0] m_word = '0;
  int          m_cnt = 0, m_busy = 0;
  logic        force0 = 1'b0;
  logic        pl_en = 1'b0;
  logic [5:0]  pl_a = '0;
  logic [15:0] pl_d = '0;

  assign sdo = force0 ? 1'b0 : (scs ? (m_rd_mode ? m_rd_bit : (m_busy == 0)) : 1'b0);

  always @(posedge clk) begin
    m_psclk <= sclk;
    m_pscs  <= scs;
    if (m_busy > 0) m_busy <= m_busy - 1;
    if (pl_en) mem[pl_a] = pl_d;
    if (scs && sclk && !m_psclk) begin
      m_rx  <= {m_rx[30:0], sdi};
      m_cnt <= m_cnt + 1;
      if (m_cnt == 8 && m_rx[6:5] == 2'b10) begin
        m_rd_mode <= 1'b1;
        m_rd_bit  <= 1'b0;
        m_word    <= mem[{m_rx[4:0], sdi}];
      end else if (m_rd_mode) begin
        m_rd_bit <= m_word[15];
        m_word   <= {m_word[14:0], 1'b0};
      end
    end
    if (!scs && m_pscs) begin
      m_rd_mode <= 1'b0;
      m_cnt     <= 0;
      m_rx      <= '0;
      if (m_cnt == 9) begin
        if (m_rx[7:6] == 2'b11 && m_ewen) begin
          mem[m_rx[5:0]] = 16'hFFFF; m_busy <= BUSY;
        end else if (m_rx[7:6] == 2'b00) begin
          case (m_rx[5:4])
            2'b11: m_ewen <= 1'b1;
            2'b00: m_ewen <= 1'b0;
            2'b10: if (m_ewen) begin
                     for (int i = 0; i < 64; i++) mem[i] = 16'hFFFF;
                     m_busy <= BUSY;
                   end
            default: ;
          endcase
        end
      end else if (m_cnt == 25 && m_ewen) begin
        if (m_rx[23:22] == 2'b01) begin
          mem[m_rx[21:16]] = m_rx[15:0]; m_busy <= BUSY;
        end else if (m_rx[23:22] == 2'b00 && m_rx[21:20] == 2'b01) begin
          for (int i = 0; i < 64; i++) mem[i] = m_rx[15:0];
          m_busy <= BUSY;
        end
      end
    end
  end

  // ---------------- Pin monitor ----------------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_rise = 0, n_scs_rise = 0, n_done = 0, n_rdv = 0;
  int   rise_cyc [0:1023];
  logic rise_sdi [0:1023];
  int   scs_rise_cyc = 0, scs_fall_cyc = 0, win = 0, last_win = 0;
  int   done_cyc = 0, rdv_cyc = 0;
  logic done_err = 1'b0, mp_sclk = 1'b0, mp_scs = 1'b0;

  always @(negedge clk) begin
    if (scs && sclk && !mp_sclk) begin
      if (n_rise < 1024) begin rise_cyc[n_rise] = cyc; rise_sdi[n_rise] = sdi; end
      n_rise++;
    end
    if (scs && !mp_scs) begin n_scs_rise++; scs_rise_cyc = cyc; win = 0; end
    if (scs) win++;
    if (!scs && mp_scs) begin last_win = win; scs_fall_cyc = cyc; end
    if (done) begin n_done++; done_cyc = cyc; done_err = err; end
    if (rd_valid) begin n_rdv++; rdv_cyc = cyc; end
    mp_sclk = sclk;
    mp_scs  = scs;
  end

  // ---------------- Checking helpers ----------------
  int n_cmp = 0, n_fail = 0;
  int acc_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [5:0] a, input logic [15:0] d);
    int t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 1000) begin @(negedge clk); t++; end
    cmd_op = op; cmd_addr = a; cmd_data = d; cmd_valid = 1'b1; acc_cyc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int base, input string tag);
    int t = 0;
    while (n_done == base && t < 3000) begin @(negedge clk); #1; t++; end
    chk({tag, "_done_seen"}, 32'(n_done != base), 32'd1);
  endtask

  task automatic preload(input logic [5:0] a, input logic [15:0] d);
    @(negedge clk); pl_en = 1'b1; pl_a = a; pl_d = d;
    @(negedge clk); pl_en = 1'b0;
  endtask

  task automatic do_read(input logic [5:0] a, input logic [15:0] exp, input string tag);
    int bd;
    bd = n_done;
    issue(3'd0, a, 16'h0);
    wait_done(bd, tag);
    chk({tag, "_data"}, 32'(rd_data), 32'(exp));
    chk({tag, "_err"}, 32'(done_err), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bd, br, bs, bv;
    logic [8:0] hdr;

    // Reset state
    #12;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_scs", 32'(scs), 32'd0);
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_sdi", 32'(sdi), 32'd0);
    chk("rst_outs", 32'({rd_valid, done, err}), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // READ 0x2A preloaded with 0xBEEF, with a stray command while busy
    preload(6'h2A, 16'hBEEF);
    bd = n_done; br = n_rise; bs = n_scs_rise; bv = n_rdv;
    issue(3'd0, 6'h2A, 16'h0);
    repeat (20) @(negedge clk);
    cmd_op = 3'd1; cmd_addr = 6'h2A; cmd_data = 16'h0000; cmd_valid = 1'b1;
    repeat (5) @(negedge clk);
    cmd_valid = 1'b0;
    wait_done(bd, "rd2a");
    chk("rd2a_data", 32'(rd_data), 32'h0000BEEF);
    chk("rd2a_err", 32'(done_err), 32'd0);
    chk("rd2a_rdv_count", 32'(n_rdv - bv), 32'd1);
    chk("rd2a_edges", 32'(n_rise - br), 32'd25);
    for (int i = 0; i < 9; i++) hdr[8-i] = rise_sdi[br+i];
    chk("rd2a_sdi_header", 32'(hdr), 32'h1AA);
    chk("rd2a_scs_rise_lat", 32'(scs_rise_cyc - acc_cyc), 32'd1);
    chk("rd2a_first_rise_lat", 32'(rise_cyc[br] - acc_cyc), 32'(1 + CLKDIV));
    chk("rd2a_rise_period", 32'(rise_cyc[br+1] - rise_cyc[br]), 32'(2 * CLKDIV));
    chk("rd2a_rdv_at_scs_fall", 32'(rdv_cyc), 32'(scs_fall_cyc));
    chk("rd2a_done_after_rdv", 32'(done_cyc - rdv_cyc), 32'(2 * CLKDIV + 1));
    repeat (10) @(negedge clk);
    chk("rd2a_single_done", 32'(n_done - bd), 32'd1);
    chk("rd2a_stray_ignored", 32'(n_scs_rise - bs), 32'd1);

    // EWEN, WRITE 0x05 = 0x1234, READ back
    bd = n_done;
    issue(3'd3, 6'h0, 16'h0);
    wait_done(bd, "ewen");
    chk("ewen_model", 32'(m_ewen), 32'd1);
    chk("ewen_err", 32'(done_err), 32'd0);
    bd = n_done; br = n_rise; bs = n_scs_rise;
    issue(3'd1, 6'h05, 16'h1234);
    wait_done(bd, "wr05");
    chk("wr05_err", 32'(done_err), 32'd0);
    chk("wr05_edges", 32'(n_rise - br), 32'd25);
    chk("wr05_poll_entered", 32'(n_scs_rise - bs), 32'd2);
    chk("wr05_poll_short", 32'(last_win < TOUT), 32'd1);
    chk("wr05_mem", 32'(mem[5]), 32'h1234);
    repeat (5) @(negedge clk);
    chk("wr05_single_done", 32'(n_done - bd), 32'd1);
    do_read(6'h05, 16'h1234, "rd05");

    // ERAL, then both ends of the address space read 0xFFFF
    bd = n_done;
    issue(3'd5, 6'h0, 16'h0);
    wait_done(bd, "eral");
    chk("eral_err", 32'(done_err), 32'd0);
    do_read(6'h00, 16'hFFFF, "rd00");
    do_read(6'h3F, 16'hFFFF, "rd3f");

    // Ready never seen during POLL: timeout error
    force0 = 1'b1;
    bd = n_done;
    issue(3'd1, 6'h07, 16'h5555);
    wait_done(bd, "tout");
    chk("tout_err", 32'(done_err), 32'd1);
    chk("tout_poll_len", 32'(last_win), 32'(TOUT));
    @(negedge clk); #1;
    chk("tout_scs_low", 32'(scs), 32'd0);
    chk("tout_ready", 32'(cmd_ready), 32'd1);
    force0 = 1'b0;
    repeat (BUSY + 10) @(negedge clk);

    // Reset in the middle of a WRITE frame aborts it
    preload(6'h09, 16'hAAAA);
    bd = n_done;
    issue(3'd1, 6'h09, 16'h0F0F);
    repeat (60) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_pins", 32'({scs, sclk, sdi}), 32'd0);
    chk("rst_mid_ready", 32'(cmd_ready), 32'd1);
    chk("rst_mid_rd_data", 32'(rd_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    chk("rst_mid_mem", 32'(mem[9]), 32'hAAAA);
    chk("rst_mid_no_done", 32'(n_done - bd), 32'd0);
    do_read(6'h09, 16'hAAAA, "rd09");

    // Reserved op: no pin activity, done+err one cycle after acceptance
    bd = n_done; br = n_rise; bs = n_scs_rise;
    issue(3'd7, 6'h0, 16'h0);
    wait_done(bd, "rsv");
    chk("rsv_done_lat", 32'(done_cyc - acc_cyc), 32'd1);
    chk("rsv_err", 32'(done_err), 32'd1);
    repeat (5) @(negedge clk);
    chk("rsv_no_edges", 32'(n_rise - br), 32'd0);
    chk("rsv_no_scs", 32'(n_scs_rise - bs), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
